// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter between CPU fetch and program loader.
// Round-robin on contention, exclusive loader bursts under lock, 1-cycle response pipeline.
module imem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic [31:0]           f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    output logic                  cpu_stall,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [31:0]           l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    input  logic                  l_lock,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [DATA_WIDTH-1:0] l_rdata,
    output logic                  locked,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [IDX_WIDTH-1:0]  mem_idx,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

    // rr holds the winner of the last contested cycle
    localparam logic RR_FETCH  = 1'b0;
    localparam logic RR_LOADER = 1'b1;

    state_t state;
    logic   rr;
    logic   resp_f;
    logic   resp_l;
    logic   resp_rd;
    logic   in_arb;
    logic   contest;
    logic   unused_addr_bits;

    assign in_arb  = (state == ARB);
    assign contest = in_arb & f_req & l_req;

    // Grant decision; everything is forced low while reset is asserted
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (reset) begin
            if (!in_arb) begin
                l_gnt = l_req;
            end else if (contest) begin
                f_gnt = (rr == RR_LOADER);
                l_gnt = (rr == RR_FETCH);
            end else begin
                f_gnt = f_req;
                l_gnt = l_req;
            end
        end
    end

    assign cpu_stall = reset & f_req & ~f_gnt;
    assign locked    = (state == LOCK);

    assign mem_en    = f_gnt | l_gnt;
    assign mem_we    = l_gnt & l_we;
    assign mem_idx   = f_gnt ? f_addr[IDX_WIDTH+1:2] :
                       l_gnt ? l_addr[IDX_WIDTH+1:2] : '0;
    assign mem_wdata = l_gnt ? l_wdata : '0;

    assign f_rvalid  = resp_f;
    assign f_rdata   = resp_f ? mem_rdata : '0;
    assign l_rvalid  = resp_l;
    assign l_rdata   = (resp_l & resp_rd) ? mem_rdata : '0;

    assign unused_addr_bits = ^{f_addr[31:IDX_WIDTH+2], f_addr[1:0],
                                l_addr[31:IDX_WIDTH+2], l_addr[1:0]};

    // Lock FSM, round-robin pointer and response flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ARB;
            rr      <= RR_LOADER;
            resp_f  <= 1'b0;
            resp_l  <= 1'b0;
            resp_rd <= 1'b0;
        end else begin
            resp_f  <= f_gnt;
            resp_l  <= l_gnt;
            resp_rd <= l_gnt & ~l_we;
            case (state)
                ARB: begin
                    if (contest) begin
                        rr <= l_gnt ? RR_LOADER : RR_FETCH;
                    end
                    if (l_lock) begin
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (!l_lock) begin
                        state <= ARB;
                        rr    <= RR_LOADER;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus random traffic
// against a behavioural model with a shadow copy of memory.
module tb_imem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          f_req, l_req, l_we, l_lock;
    logic [31:0]   f_addr, l_addr;
    logic [DW-1:0] l_wdata;
    logic          f_gnt, f_rvalid, cpu_stall, l_gnt, l_rvalid, locked;
    logic          mem_en, mem_we;
    logic [DW-1:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
    logic [IW-1:0] mem_idx;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem    [256];
    logic [DW-1:0] shadow [256];

    // model state
    bit            m_lock;
    bit            m_last_loader;
    bit            pend_f, pend_l;
    logic [DW-1:0] pend_fdata, pend_ldata;

    always #5 clk = ~clk;

    imem_arbiter #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .cpu_stall(cpu_stall),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .locked(locked), .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // synchronous-read memory seen by the DUT
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_idx] <= mem_wdata;
            else        mem_rdata <= mem[mem_idx];
        end
    end

    function automatic logic [DW-1:0] init_word(int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock        = 1'b0;
        m_last_loader = 1'b1;
        pend_f        = 1'b0;
        pend_l        = 1'b0;
        pend_fdata    = '0;
        pend_ldata    = '0;
    endtask

    // who the rules say gets the port right now
    task automatic model_grant(output bit ef, output bit el);
        ef = 1'b0;
        el = 1'b0;
        if (reset) begin
            if (m_lock)              el = l_req;
            else if (f_req && l_req) begin
                if (m_last_loader) ef = 1'b1;
                else               el = 1'b1;
            end else begin
                ef = f_req;
                el = l_req;
            end
        end
    endtask

    // inputs already driven; check every output, advance model, move to next negedge
    task automatic cycle();
        bit            ef, el;
        int            fi, li;
        logic [31:0]   exp_idx, exp_wd;
        #1;
        if (!reset) model_reset();
        model_grant(ef, el);
        fi = int'(f_addr[IW+1:2]);
        li = int'(l_addr[IW+1:2]);
        exp_idx = ef ? 32'(fi) : (el ? 32'(li) : 32'd0);
        exp_wd  = el ? l_wdata : 32'd0;
        check("f_gnt",     32'(f_gnt),     32'(ef));
        check("l_gnt",     32'(l_gnt),     32'(el));
        check("cpu_stall", 32'(cpu_stall), 32'(reset && f_req && !ef));
        check("mem_en",    32'(mem_en),    32'(ef || el));
        check("mem_we",    32'(mem_we),    32'(el && l_we));
        check("mem_idx",   32'(mem_idx),   exp_idx);
        check("mem_wdata", mem_wdata,      exp_wd);
        check("locked",    32'(locked),    32'(m_lock));
        check("f_rvalid",  32'(f_rvalid),  32'(pend_f));
        check("f_rdata",   f_rdata,        pend_f ? pend_fdata : 32'd0);
        check("l_rvalid",  32'(l_rvalid),  32'(pend_l));
        check("l_rdata",   l_rdata,        pend_l ? pend_ldata : 32'd0);
        if (reset) begin
            if (ef) pend_fdata = shadow[fi];
            pend_ldata = '0;
            if (el && !l_we) pend_ldata = shadow[li];
            if (el && l_we)  shadow[li] = l_wdata;
            pend_f = ef;
            pend_l = el;
            if (!m_lock && f_req && l_req) m_last_loader = el;
            if (m_lock && !l_lock) begin
                m_lock        = 1'b0;
                m_last_loader = 1'b1;
            end else if (!m_lock && l_lock) begin
                m_lock = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(bit fr, logic [31:0] fa, bit lr, bit lw,
                         logic [31:0] la, logic [DW-1:0] ld, bit lk);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw;
        l_addr = la; l_wdata = ld; l_lock = lk;
    endtask

    initial begin
        int n;
        int guard;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
        mem_rdata = '0;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        cycle();
        reset = 1'b1;

        // reset mid-access
        drive(1, 32'h0, 0, 0, 0, 0, 0);
        cycle();
        reset = 1'b0;
        #1;
        check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        check("rst_f_gnt",    32'(f_gnt),    32'd0);
        cycle();
        reset = 1'b1;

        // contention: fetch wins first contest after reset, then alternate
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h0, 1, 0, 32'h40, 0, 0);
            #1;
            check("cont_f_gnt", 32'(f_gnt),     32'((i % 2) == 0));
            check("cont_stall", 32'(cpu_stall), 32'((i % 2) == 1));
            if (i == 2) check("cont_l_rdata", l_rdata, init_word(16));
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // fetch only
        for (int i = 1; i <= 3; i++) begin
            drive(1, 32'(i * 4), 0, 0, 0, 0, 0);
            #1;
            check("fo_idx", 32'(mem_idx), 32'(i));
            if (i > 1) check("fo_rdata", f_rdata, init_word(i - 1));
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("fo_rdata_last", f_rdata, init_word(3));
        cycle();

        // lock burst of four writes while fetch is waiting
        n = 0;
        guard = 0;
        while (n < 4 && guard < 20) begin
            drive(1, 32'h100, 1, 1, 32'(n * 4), 32'h2000_0008, 1);
            #1;
            if (guard > 0) begin
                check("lk_locked", 32'(locked),    32'd1);
                check("lk_f_gnt",  32'(f_gnt),     32'd0);
                check("lk_stall",  32'(cpu_stall), 32'd1);
            end
            if (l_gnt) n++;
            guard++;
            cycle();
        end
        check("lk_writes", 32'(n), 32'd4);
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        #1;
        check("lk_ack_rdata", l_rdata, 32'd0);
        cycle();
        drive(1, 32'h100, 1, 0, 32'h8, 0, 0);
        #1;
        check("unlock_fetch_wins", 32'(f_gnt), 32'd1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // write then read next cycle
        drive(0, 0, 1, 1, 32'h3FC, 32'hDEAD_BEEF, 0);
        cycle();
        drive(1, 32'h3FC, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("wr_rd_data", f_rdata, 32'hDEAD_BEEF);
        cycle();

        // address alias
        drive(1, 32'h402, 0, 0, 0, 0, 0);
        #1;
        check("alias_idx", 32'(mem_idx), 32'd0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("alias_data", f_rdata, 32'h2000_0008);
        cycle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 7) == 0) l_lock = ~l_lock;
            f_req   = ($urandom_range(0, 3) != 0);
            l_req   = ($urandom_range(0, 2) != 0);
            l_we    = $urandom_range(0, 1) == 1;
            f_addr  = $urandom;
            l_addr  = $urandom;
            l_wdata = $urandom;
            cycle();
        end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction-memory port between the CPU fetch unit and the program loader, which reads, writes and verifies program images.
- Memory has synchronous read: data valid one cycle after enable. Word index is address bits [9:2], 256 words.
- Arbitrates round-robin on contention, grants the loader exclusive burst access under a lock, and stalls the CPU while fetch is blocked.

Parameters:
- DATA_WIDTH, 32, instruction/data word width.
- IDX_WIDTH, 8, word-index width taken from address bits [IDX_WIDTH+1:2].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- f_req  input  1  fetch request.
- f_addr  input  32  fetch byte address.
- f_gnt  output  1  fetch granted this cycle (combinational).
- f_rvalid  output  1  fetch read data valid.
- f_rdata  output  DATA_WIDTH  fetch read data.
- cpu_stall  output  1  f_req high and f_gnt low (combinational).
- l_req  input  1  loader request.
- l_we  input  1  loader write (1) / read (0).
- l_addr  input  32  loader byte address.
- l_wdata  input  DATA_WIDTH  loader write data.
- l_lock  input  1  loader requests exclusive access.
- l_gnt  output  1  loader granted this cycle (combinational).
- l_rvalid  output  1  loader response valid (read data or write ack).
- l_rdata  output  DATA_WIDTH  loader read data.
- locked  output  1  FSM is in LOCK.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_idx  output  IDX_WIDTH  word index.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_en.

Behaviour:
- FSM states: ARB, LOCK. Reset state is ARB.
  - ARB->LOCK at the clock edge where l_lock=1.
  - LOCK->ARB at the clock edge where l_lock=0.
- ARB grants, one requester per cycle:
  - Only f_req: f_gnt=1.
  - Only l_req: l_gnt=1.
  - Both: grant the requester opposite to the rr pointer. The rr pointer is a 1-bit register holding the last winner of a contested cycle. It updates only on contested cycles. Reset value is "loader", so fetch wins the first contest.
- LOCK grants: f_gnt=0, l_gnt=l_req. cpu_stall follows f_req.
- On leaving LOCK, rr is set to "loader", so fetch wins the next contest.
- Memory drive:
  - mem_en = f_gnt | l_gnt.
  - mem_we = l_gnt & l_we.
  - mem_idx and mem_wdata come from the granted requester's address and data.
  - mem_idx and mem_wdata are 0 when idle.
  - Address bits [1:0] and bits above the index are ignored; no alignment fault.
- Response pipeline:
  - Registered flags resp_f and resp_l are set at the edge after the grant.
  - f_rvalid=resp_f; f_rdata=mem_rdata when resp_f, else 0.
  - l_rvalid=resp_l; l_rdata=mem_rdata when resp_l and the granted access was a read. The read/write flag is registered with resp_l. l_rdata=0 for write acks and when idle.
  - Latency is exactly 1 cycle. Back-to-back grants give back-to-back responses.
- The requester holds req/addr/data until it sees gnt. Dropping req before gnt is legal; no response is issued.
- A write granted at cycle N is visible to any read granted at N+1 or later.
- Asynchronous reset (reset=0), including mid-access:
  - FSM goes to ARB, rr to "loader", resp_f and resp_l to 0.
  - All outputs go to 0. Any outstanding response is dropped.
- l_lock asserted in the same cycle as a contested ARB grant: that cycle still arbitrates normally. Lock takes effect the next cycle.

Test Plan:
- Reset mid-access: grant fetch at addr 0x0, assert reset=0 in the following cycle -> f_rvalid=0, all outputs 0. After release, the first contest goes to fetch.
- Fetch only: f_req=1, f_addr=0x4, 0x8, 0xC on consecutive cycles.
  - Required: f_gnt=1 each cycle, mem_idx=1,2,3.
  - Required: f_rvalid=1 one cycle later, f_rdata = mem word at each index.
  - Required: cpu_stall=0 throughout.
- Contention: f_req and l_req (read, 0x40) held high for 4 cycles.
  - Required: grants alternate fetch, loader, fetch, loader.
  - Required: cpu_stall=1 on loader cycles, l_rdata = word 16.
- Lock burst: l_lock=1 with loader writes 0x20000008 to idx 0..3 while f_req=1.
  - Required: locked=1 from the next cycle, f_gnt=0, cpu_stall=1, four write acks with l_rdata=0.
  - After l_lock=0: ARB resumes and fetch wins the first contest.
- Write then read: loader writes 0xDEADBEEF at 0x3FC, then fetch reads 0x3FC next cycle -> f_rdata=0xDEADBEEF.
- Address alias: f_addr=0x402 -> mem_idx=0x00, data = word 0.
